aes_key_schedule_store: RTL
===========================

// Module: aes_key_schedule_store
// PURPOSE
//  Byte-serial round-key store: consumer side of the key schedule generator's fast output.
//  - Captures the (NUM_ROUNDS+1)*16-byte expanded key as it is written out one byte per cycle.
//  - Replays it to the AES core byte-serially over a valid/ready stream.
//  - Round order: 0..NUM_ROUNDS for encrypt, NUM_ROUNDS..0 for decrypt.
//  - Byte order inside each round is always 0..15.
// PARAMETERS
//  NUM_ROUNDS       10  AES rounds; depth = (NUM_ROUNDS+1)*16 (176 for AES-128)
//  BYTES_PER_ROUND  16  bytes per round key
// PORTS
//  clk             in   1  clock; all logic on rising edge
//  rst             in   1  synchronous, active-high reset
//  wr_start        in   1  pulse: restart capture at byte 0, clear schedule_valid
//  wr_en           in   1  wr_byte valid this cycle
//  wr_byte         in   8  key schedule byte from generator (round_key_fast)
//  schedule_valid  out  1  all DEPTH bytes captured since last wr_start
//  rd_start        in   1  pulse: begin replay
//  rd_decrypt      in   1  sampled with rd_start: 1 = reverse round order
//  rd_ready        in   1  core accepts rd_byte
//  rd_valid        out  1  rd_byte/rd_round/rd_last valid
//  rd_byte         out  8  round key byte
//  rd_round        out  4  round index of rd_byte
//  rd_last         out  1  final byte of the replay
//  rd_parity_err   out  1  stored-byte parity mismatch (see CONFIGURATION)
//  busy            out  1  read FSM not IDLE
// BEHAVIOUR
//  Reset: schedule_valid, rd_valid, rd_last, rd_parity_err, busy = 0; rd_byte, rd_round = 0.
//    Pointers and FSM = 0/IDLE. RAM contents are not reset.
//  Write side:
//  - wr_start: wr_ptr <= 0, schedule_valid <= 0. wr_en in the same cycle is ignored.
//  - wr_en: RAM[wr_ptr] <= wr_byte, wr_ptr++.
//  - The write of byte DEPTH-1 sets schedule_valid the next cycle.
//  - Further wr_en is ignored until the next wr_start (no wrap-around).
//  Read FSM: IDLE -> PRIME -> STREAM -> IDLE.
//  - IDLE: rd_start && schedule_valid && !wr_start latches dir. Start addr = 0 (enc) or NUM_ROUNDS*16 (dec).
//    Otherwise rd_start is ignored (no error flag).
//  - PRIME: one cycle for the synchronous RAM read. rd_valid rises on the next cycle (latency 2 from rd_start).
//  - STREAM: rd_byte/rd_round/rd_last held stable while rd_valid && !rd_ready.
//    Accept = rd_valid && rd_ready. RAM read addr = accept ? next_addr : cur_addr, giving 1 byte/cycle with no bubbles.
//    next_addr: byte++ within the round; at byte 15 go to round+1 (enc) or round-1 (dec), byte 0.
//  - rd_last = 1 on round NUM_ROUNDS byte 15 (enc) or round 0 byte 15 (dec).
//    Accept with rd_last -> IDLE, rd_valid <= 0.
//  - rd_start while busy is ignored.
//  Abort: wr_start in any read state -> IDLE next cycle, rd_valid/rd_last <= 0; no further bytes emitted.
//  Simultaneous write/read: not allowed, because reads require schedule_valid and writes after it are ignored.
//  rd_round width = 4 bits; NUM_ROUNDS <= 15 is enforced by an elaboration assertion.
// CONFIGURATION
//  `AES_KS_PARITY_EN defined:
//  - RAM is 9 bits wide; bit 8 = ^wr_byte is stored with each byte.
//  - rd_parity_err = rd_valid && (^rd_byte != stored parity); it has the same timing and hold behaviour as rd_byte.
//  - Data flow is unaffected (flag only).
//  Not defined: RAM is 8 bits wide; rd_parity_err is tied to 0. The port list is identical in both builds.
// STRUCTURE
//  Package aes_ks_pkg:
//  - KS_BYTES_PER_ROUND, ks_depth(NUM_ROUNDS) function, KS_ADDR_W;
//  - typedef enum logic [1:0] {KS_IDLE, KS_PRIME, KS_STREAM} ks_rd_state_t;
//  - typedef ks_word_t (8- or 9-bit, macro-selected).
//  Sub-module aes_ks_ram:
//  - simple dual-port, 1 write port, 1 synchronous read port;
//  - registered output with read enable (hold when not enabled);
//  - no reset.
//  Top level holds the write pointer, read address/round/byte counters, FSM and flags.
// TESTING
//  1. Write 176 bytes 0x00..0xAF, then rd_start enc, rd_ready = 1.
//     -> rd_valid 2 cycles later; bytes 0x00..0xAF on 176 consecutive cycles;
//        rd_round steps 0..10; rd_last only on 0xAF.
//  2. Same data, rd_start with rd_decrypt = 1.
//     -> 0xA0..0xAF (round 10), 0x90..0x9F (round 9), ... 0x00..0x0F (round 0); rd_last on 0x0F.
//  3. Random rd_ready (50%) on enc replay.
//     -> rd_byte held while stalled; the accepted sequence equals scenario 1 exactly; no duplicates or drops.
//  4. Write only 100 bytes, then rd_start.
//     -> ignored, busy = 0. Write 76 more and 5 extra bytes -> schedule_valid = 1; extras not stored.
//  5. wr_start at byte 40 of a replay.
//     -> rd_valid 0 next cycle, busy 0, schedule_valid 0. rst mid-replay -> all outputs 0 next cycle.
//  6. `AES_KS_PARITY_EN: force-flip RAM bit 3 of address 0x25.
//     -> rd_parity_err = 1 only while byte 0x25 is presented; the byte stream is otherwise unchanged.

Source files
------------

// File: rtl/aes_ks_pkg.sv
// Shared types and sizing helpers for the byte-serial AES round-key store.
// AES_KS_PARITY_EN widens each stored word with an even-parity bit.
package aes_ks_pkg;

  localparam int KS_BYTES_PER_ROUND = 16;
  localparam int KS_ADDR_W          = 8;

  typedef enum logic [1:0] {KS_IDLE, KS_PRIME, KS_STREAM} ks_rd_state_t;

`ifdef AES_KS_PARITY_EN
  typedef logic [8:0] ks_word_t;
`else
  typedef logic [7:0] ks_word_t;
`endif

  function automatic int ks_depth(input int num_rounds);
    return (num_rounds + 1) * KS_BYTES_PER_ROUND;
  endfunction

endpackage

// File: rtl/aes_ks_ram.sv
// Simple dual-port key storage: one write port and one registered read port.
// The read register holds its value while rd_en is low. No reset on contents.
module aes_ks_ram
  import aes_ks_pkg::*;
#(
  parameter int DEPTH = 176
) (
  input  logic                 clk,
  input  logic                 wr_en,
  input  logic [KS_ADDR_W-1:0] wr_addr,
  input  ks_word_t             wr_data,
  input  logic                 rd_en,
  input  logic [KS_ADDR_W-1:0] rd_addr,
  output ks_word_t             rd_data
);

  ks_word_t mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/aes_key_schedule_store.sv
// Captures an expanded AES key byte-serially and replays it over a valid/ready stream,
// forward (encrypt) or in reverse round order (decrypt). Optional AES_KS_PARITY_EN.
module aes_key_schedule_store
  import aes_ks_pkg::*;
#(
  parameter int NUM_ROUNDS      = 10,
  parameter int BYTES_PER_ROUND = KS_BYTES_PER_ROUND
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_start,
  input  logic       wr_en,
  input  logic [7:0] wr_byte,
  output logic       schedule_valid,
  input  logic       rd_start,
  input  logic       rd_decrypt,
  input  logic       rd_ready,
  output logic       rd_valid,
  output logic [7:0] rd_byte,
  output logic [3:0] rd_round,
  output logic       rd_last,
  output logic       rd_parity_err,
  output logic       busy
);

  localparam int                   DEPTH      = ks_depth(NUM_ROUNDS);
  localparam logic [3:0]           LAST_ROUND = 4'(NUM_ROUNDS);
  localparam logic [KS_ADDR_W-1:0] LAST_WR    = KS_ADDR_W'(DEPTH - 1);

  generate
    if (NUM_ROUNDS < 1 || NUM_ROUNDS > 15) begin : g_bad_rounds
      $error("aes_key_schedule_store: NUM_ROUNDS must be 1..15");
    end
    if (BYTES_PER_ROUND != KS_BYTES_PER_ROUND) begin : g_bad_bpr
      $error("aes_key_schedule_store: BYTES_PER_ROUND must be 16");
    end
  endgenerate

  logic [KS_ADDR_W-1:0] wr_ptr_reg;
  logic                 schedule_valid_reg;
  logic                 wr_accept;
  ks_word_t             ram_wdata;
  ks_word_t             ram_rdata;
  logic                 ram_re;
  logic [KS_ADDR_W-1:0] ram_raddr;

  assign wr_accept      = wr_en && !wr_start && !schedule_valid_reg;
  assign schedule_valid = schedule_valid_reg;

`ifdef AES_KS_PARITY_EN
  assign ram_wdata = {^wr_byte, wr_byte};
`else
  assign ram_wdata = wr_byte;
`endif

  // No wrap-around: once full, writes are dropped until the next wr_start.
  always_ff @(posedge clk) begin
    if (rst || wr_start) begin
      wr_ptr_reg         <= '0;
      schedule_valid_reg <= 1'b0;
    end else if (wr_accept) begin
      wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (wr_ptr_reg == LAST_WR) schedule_valid_reg <= 1'b1;
    end
  end

  ks_rd_state_t state_reg, state_next;
  logic         dec_reg;
  logic [3:0]   round_reg, byte_reg;
  logic [3:0]   round_next, byte_next;
  logic         is_last, accept, start_load;

  assign rd_valid = (state_reg == KS_STREAM);
  assign busy     = (state_reg != KS_IDLE);
  assign accept   = rd_valid && rd_ready;
  assign is_last  = (byte_reg == 4'd15) && (round_reg == (dec_reg ? 4'd0 : LAST_ROUND));

  always_comb begin
    byte_next  = byte_reg + 4'd1;
    round_next = round_reg;
    if (byte_reg == 4'd15) round_next = dec_reg ? round_reg - 4'd1 : round_reg + 4'd1;
  end

  always_comb begin
    state_next = state_reg;
    ram_re     = 1'b0;
    ram_raddr  = {round_reg, byte_reg};
    start_load = 1'b0;
    case (state_reg)
      KS_IDLE: begin
        if (rd_start && schedule_valid_reg && !wr_start) begin
          state_next = KS_PRIME;
          start_load = 1'b1;
        end
      end
      KS_PRIME: begin
        ram_re     = 1'b1;
        state_next = KS_STREAM;
      end
      KS_STREAM: begin
        // Prefetch the following byte on accept so the stream has no bubbles.
        if (accept) begin
          if (is_last) begin
            state_next = KS_IDLE;
          end else begin
            ram_re    = 1'b1;
            ram_raddr = {round_next, byte_next};
          end
        end
      end
      default: state_next = KS_IDLE;
    endcase
    if (wr_start && state_reg != KS_IDLE) begin
      state_next = KS_IDLE;
      ram_re     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= KS_IDLE;
      dec_reg   <= 1'b0;
      round_reg <= '0;
      byte_reg  <= '0;
    end else begin
      state_reg <= state_next;
      if (start_load) begin
        dec_reg   <= rd_decrypt;
        round_reg <= rd_decrypt ? LAST_ROUND : 4'd0;
        byte_reg  <= '0;
      end else if (state_reg == KS_STREAM && accept && !is_last && !wr_start) begin
        round_reg <= round_next;
        byte_reg  <= byte_next;
      end
    end
  end

  aes_ks_ram #(.DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (ram_wdata),
    .rd_en   (ram_re),
    .rd_addr (ram_raddr),
    .rd_data (ram_rdata)
  );

  // Outputs are zero whenever no byte is being presented.
  assign rd_byte  = rd_valid ? ram_rdata[7:0] : 8'h00;
  assign rd_round = rd_valid ? round_reg : 4'd0;
  assign rd_last  = rd_valid && is_last;

`ifdef AES_KS_PARITY_EN
  assign rd_parity_err = rd_valid && ((^ram_rdata[7:0]) != ram_rdata[8]);
`else
  assign rd_parity_err = 1'b0;
`endif

endmodule
